uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_sync2.sv | 22 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period,
// kept in one place so a companion transmitter can use the same values.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; presets to 1
// so that reset looks like an idle (marking) line.
module sync2 (
  input  logic clk,
  input  logic reset_bar,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, holds the last good byte
// for a consumer, and flags overruns and framing errors.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          rxd_s;
  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          overrun_q;
  logic          frame_err_q;
  logic          busy_q;

  sync2 u_sync (
    .clk       (clk),
    .reset_bar (reset_bar),
    .d_i       (rxd),
    .q_o       (rxd_s)
  );

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (rd && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rxd_s) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxd_s;
            if (idx_q == 3'd7) state_q <= ST_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              data_q  <= shift_q;
              valid_q <= 1'b1;
              // A same-cycle rd consumes the old byte, so no overrun then.
              if (valid_q && !rd) overrun_q <= 1'b1;
            end else begin
              state_q     <= ST_BREAK;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_BREAK: begin
          if (rxd_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random bytes,
// checked against a byte-level model of the receive buffer.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       rxd;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int fe_count = 0;

  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .rxd       (rxd),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_count <= fe_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"}, {24'd0, data}, {24'd0, exp_data});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_valid});
    check({tag, ".overrun"}, {31'd0, overrun}, {31'd0, exp_overrun});
  endtask

  // Buffer model: a completed byte always loads; it overruns only if the
  // previous byte is still held and not being consumed in that same cycle.
  task automatic model_byte(input logic [7:0] b, input logic rd_same);
    if (exp_valid && !rd_same) exp_overrun = 1'b1;
    else if (exp_valid && rd_same) exp_overrun = 1'b0;
    exp_data  = b;
    exp_valid = 1'b1;
  endtask

  task automatic consume();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // One full 10-bit frame; rd is raised for the single cycle rd_cycle
  // (-1 for never). Cycle i's inputs are seen at the edge ending cycle i.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int rd_cycle);
    int k;
    for (int i = 0; i < 10 * CPB; i++) begin
      k = i / CPB;
      if (k == 0)      rxd = 1'b0;
      else if (k == 9) rxd = stop_val;
      else             rxd = b[k-1];
      rd = (i == rd_cycle);
      tick();
    end
    rd = 1'b0;
  endtask

  initial begin
    int fe0;
    int bc;
    logic [7:0] rb;
    int k;

    reset_bar   = 1'b0;
    rxd         = 1'b1;
    rd          = 1'b0;
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    repeat (3) tick();
    check_model("reset");
    check("reset.frame_err", {31'd0, frame_err}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    reset_bar = 1'b1;
    idle(4);

    // Clean byte
    fe0 = fe_count;
    send_frame(8'h55, 1'b1, -1);
    model_byte(8'h55, 1'b0);
    idle(2);
    check_model("byte55");
    check("byte55.no_frame_err", fe_count - fe0, 32'd0);
    check("byte55.busy_idle", {31'd0, busy}, 32'd0);
    consume();
    check_model("byte55.consumed");

    // Overrun then acknowledge
    send_frame(8'h11, 1'b1, -1);
    model_byte(8'h11, 1'b0);
    idle(3);
    send_frame(8'h22, 1'b1, -1);
    model_byte(8'h22, 1'b0);
    idle(2);
    check_model("overrun");
    consume();
    check_model("overrun.ack");

    // Short low glitch must not start a reception
    fe0 = fe_count;
    bc = 0;
    rxd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy === 1'b1) bc++;
    end
    rxd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) bc++;
    end
    check("glitch.busy_1_to_10", {31'd0, (bc >= 1 && bc <= 10)}, 32'd1);
    check("glitch.busy_idle", {31'd0, busy}, 32'd0);
    check("glitch.no_frame_err", fe_count - fe0, 32'd0);
    check_model("glitch");

    // Framing error followed by a held-low break
    fe0 = fe_count;
    send_frame(8'h7E, 1'b0, -1);
    rxd = 1'b0;
    repeat (40) tick();
    check("break.one_frame_err", fe_count - fe0, 32'd1);
    check("break.busy_held", {31'd0, busy}, 32'd1);
    check_model("break");
    idle(6);
    check("break.released", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1, -1);
    model_byte(8'h81, 1'b0);
    idle(2);
    check_model("after_break");

    // Reset in the middle of data bit 3 of 0xA5
    for (int i = 0; i < (4 * CPB + CPB / 2); i++) begin
      k = i / CPB;
      if (k == 0) rxd = 1'b0;
      else        rb = 8'hA5;
      if (k != 0) rxd = rb[k-1];
      tick();
    end
    reset_bar = 1'b0;
    #1;
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    check_model("midreset");
    check("midreset.busy", {31'd0, busy}, 32'd0);
    check("midreset.frame_err", {31'd0, frame_err}, 32'd0);
    rxd = 1'b1;
    repeat (3) tick();
    reset_bar = 1'b1;
    idle(4);
    send_frame(8'hC4, 1'b1, -1);
    model_byte(8'hC4, 1'b0);
    idle(2);
    check_model("after_reset");

    // rd on the exact completion edge: 2 + CPB/2 + 9*CPB + 1 = 155 edges
    // after the start edge is driven, i.e. inputs of frame cycle 154.
    consume();
    idle(3);
    send_frame(8'h01, 1'b1, -1);
    model_byte(8'h01, 1'b0);
    idle(3);
    send_frame(8'h02, 1'b1, 2 + CPB / 2 + 9 * CPB);
    model_byte(8'h02, 1'b1);
    idle(2);
    check_model("rd_on_complete");

    // Random bytes with random acknowledges and gaps
    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, -1);
      model_byte(rb, 1'b0);
      idle(2);
      check_model($sformatf("rand%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        consume();
        check_model($sformatf("rand%0d.ack", r));
      end
      idle(int'($urandom_range(1, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
